// File: rtl/phase_step_arbiter_if.sv
// phase_step_arbiter_if: command and status bundle between two requesters and the shared phase stepper.
interface phase_step_arbiter_if #(parameter int CNT_W = 8);
    logic             req0, req1, dir0, dir1;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             ack0, ack1, done0, done1, busy, y;
    logic [1:0]       gnt, phase;
    modport master (
        output req0, req1, dir0, dir1, cnt0, cnt1,
        input  ack0, ack1, done0, done1, busy, y, gnt, phase
    );
    modport slave (
        input  req0, req1, dir0, dir1, cnt0, cnt1,
        output ack0, ack1, done0, done1, busy, y, gnt, phase
    );
endinterface

// File: rtl/phase_step_arbiter.sv
// phase_step_arbiter: two-requester arbiter driving a shared mod-4 phase stepper, one step per cycle.
// Define PHASE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module phase_step_arbiter #(
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    phase_step_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             dir_q;
    logic             pick1;
    logic             any_req;
    assign any_req = bus.req0 | bus.req1;
    assign bus.y   = &bus.phase;
`ifdef PHASE_ARB_FIXED_PRIO_EN
    assign pick1 = bus.req1 & ~bus.req0;
`else
    logic last;
    // last = 1 means requester 1 was served most recently, so requester 0 wins the next tie
    assign pick1 = bus.req1 & ~(bus.req0 & last);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last <= 1'b1;
        else if (state == IDLE && any_req)
            last <= pick1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            dir_q     <= 1'b0;
            bus.phase <= 2'b00;
            bus.gnt   <= 2'b00;
            bus.busy  <= 1'b0;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
        end else begin
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    state    <= RUN;
                    bus.gnt  <= pick1 ? 2'b10 : 2'b01;
                    bus.ack0 <= ~pick1;
                    bus.ack1 <= pick1;
                    bus.busy <= 1'b1;
                    dir_q    <= pick1 ? bus.dir1 : bus.dir0;
                    rem      <= pick1 ? bus.cnt1 : bus.cnt0;
                end
                RUN: begin
                    if (rem != '0) begin
                        bus.phase <= dir_q ? bus.phase - 2'd1 : bus.phase + 2'd1;
                        rem       <= rem - CNT_W'(1);
                    end
                    // zero-count commands also finish after a single RUN cycle
                    if (rem[CNT_W-1:1] == '0) begin
                        state     <= DONE;
                        bus.done0 <= bus.gnt[0];
                        bus.done1 <= bus.gnt[1];
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.gnt  <= 2'b00;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_step_arbiter.sv
// tb_phase_step_arbiter: directed scenarios plus random traffic checked cycle by cycle against a timing-rule model.
module tb_phase_step_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    phase_step_arbiter_if #(.CNT_W(8)) bus ();
    phase_step_arbiter #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // Model: a command accepted at edge E0 is k edges old; its outputs follow from k, its count and direction.
    int m_act, m_k, m_n, m_neff, m_own, m_dir, m_base, m_last, m_ph;

    function automatic int mod4(int x);
        return ((x % 4) + 4) % 4;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_k = 0; m_n = 0; m_neff = 1; m_own = 0; m_dir = 0; m_base = 0; m_last = 1; m_ph = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_act != 0) begin
            m_k++;
            if (m_k > m_neff) m_act = 0;
        end else if (bus.req0 || bus.req1) begin
`ifdef PHASE_ARB_FIXED_PRIO_EN
            m_own = bus.req0 ? 0 : 1;
`else
            m_own = (bus.req0 && bus.req1) ? 1 - m_last : (bus.req1 ? 1 : 0);
`endif
            m_last = m_own;
            m_act  = 1;
            m_k    = 0;
            m_n    = m_own ? int'(bus.cnt1) : int'(bus.cnt0);
            m_dir  = m_own ? int'(bus.dir1) : int'(bus.dir0);
            m_neff = (m_n == 0) ? 1 : m_n;
            m_base = m_ph;
        end
        if (m_act != 0)
            m_ph = mod4(m_base + (m_dir ? -1 : 1) * ((m_k < m_n) ? m_k : m_n));
    endtask

    task automatic check_all();
        chk("ack0",  bus.ack0,  (m_act != 0 && m_k == 0 && m_own == 0));
        chk("ack1",  bus.ack1,  (m_act != 0 && m_k == 0 && m_own == 1));
        chk("done0", bus.done0, (m_act != 0 && m_k == m_neff && m_own == 0));
        chk("done1", bus.done1, (m_act != 0 && m_k == m_neff && m_own == 1));
        chk("gnt",   bus.gnt,   m_act != 0 ? (1 << m_own) : 0);
        chk("busy",  bus.busy,  m_act != 0);
        chk("phase", bus.phase, m_ph);
        chk("y",     bus.y,     m_ph == 3);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    function automatic logic just_acked(int who);
        return (m_act != 0 && m_k == 0 && m_own == who);
    endfunction

    task automatic drive_rand();
        if (!bus.req0 || just_acked(0)) begin
            bus.req0 = ($urandom % 3 == 0);
            bus.dir0 = 1'($urandom);
            bus.cnt0 = ($urandom % 10 == 0) ? 8'($urandom) : 8'($urandom % 5);
        end
        if (!bus.req1 || just_acked(1)) begin
            bus.req1 = ($urandom % 3 == 0);
            bus.dir1 = 1'($urandom);
            bus.cnt1 = ($urandom % 10 == 0) ? 8'($urandom) : 8'($urandom % 5);
        end
    endtask

    task automatic issue(int who, logic dir, logic [7:0] cnt, int wait_cycles);
        if (who == 0) begin bus.req0 = 1'b1; bus.dir0 = dir; bus.cnt0 = cnt; end
        else          begin bus.req1 = 1'b1; bus.dir1 = dir; bus.cnt1 = cnt; end
        cyc();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (wait_cycles) cyc();
    endtask

    initial begin
        int n_acc;
        {bus.req0, bus.req1, bus.dir0, bus.dir1} = '0;
        bus.cnt0 = '0;
        bus.cnt1 = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) cyc();
        rst_n = 1'b1;
        // cnt=5 upward from reset: 1,2,3,0,1
        issue(0, 1'b0, 8'd5, 8);
        chk("t1_phase", bus.phase, 2'd1);
        // bring phase to 0, then a single downward step lands on 3 and stays there
        issue(0, 1'b0, 8'd3, 6);
        issue(1, 1'b1, 8'd1, 5);
        chk("t2_phase", bus.phase, 2'd3);
        chk("t2_y", bus.y, 1'b1);
        // both requesting continuously with cnt=2
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.cnt0 = 8'd2; bus.cnt1 = 8'd2; bus.dir0 = 1'b0; bus.dir1 = 1'b1;
        n_acc = 0;
        repeat (16) begin
            cyc();
            if (bus.ack0 || bus.ack1) begin
`ifdef PHASE_ARB_FIXED_PRIO_EN
                chk("alt_gnt", bus.gnt, 2'b01);
`else
                chk("alt_gnt", bus.gnt, (n_acc % 2 == 0) ? 2'b01 : 2'b10);
`endif
                n_acc++;
            end
        end
        chk("alt_count", n_acc, 4);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (6) cyc();
        // zero-count command
        issue(0, 1'b1, 8'd0, 4);
        // return to phase 0, then the full 255-step run
        issue(0, 1'b1, 8'(m_ph), 8);
        chk("t5_start", bus.phase, 2'd0);
        issue(0, 1'b0, 8'd255, 258);
        chk("t5_phase", bus.phase, 2'd3);
        // asynchronous reset in the middle of a cnt=10 command
        issue(0, 1'b0, 8'd10, 2);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) cyc();
        #2;
        rst_n = 1'b1;
        issue(0, 1'b0, 8'd2, 5);
        chk("t6_phase", bus.phase, 2'd2);
        // random traffic
        repeat (3000) begin
            drive_rand();
            cyc();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (300) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
